// File: rtl/clock_pkg.sv
// Shared definitions for the on-screen clock timekeeping logic.
// Contents: edit-state enum, field limits, BCD digit type and two digit-split helpers.
package clock_pkg;

  // Encoding matches the edit_sel output: 0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.
  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSetH = 2'd1,
    StSetM = 2'd2,
    StSetS = 2'd3
  } state_e;

  localparam int unsigned HOURS_MAX  = 23;
  localparam int unsigned MINSEC_MAX = 59;

  typedef logic [3:0] bcd_t;

  function automatic bcd_t tens_of(input int unsigned v);
    return bcd_t'(v / 10);
  endfunction

  function automatic bcd_t units_of(input int unsigned v);
    return bcd_t'(v % 10);
  endfunction

endpackage

// File: rtl/clock_time_ctrl_bcd2.sv
// Two-digit BCD modulo counter used for the seconds, minutes and hours fields.
// Counts 00 .. {TensMax, UnitsTop} and wraps to 00. Units roll over at 9 below the top.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   inc          advance by one this cycle
//   clr          synchronous clear to 00 (overrides inc)
//   tens, units  registered BCD digits
//   carry        combinational, high when inc wraps the counter to 00
module bcd2_mod_counter
  import clock_pkg::*;
#(
  parameter bcd_t TensMax  = 4'd5,
  parameter bcd_t UnitsTop = 4'd9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output bcd_t tens,
  output bcd_t units,
  output logic carry
);

  bcd_t tens_d, units_d;
  logic at_top;

  assign at_top = (tens == TensMax) && (units == UnitsTop);
  // Combinational so a cascade of counters settles on the same edge.
  assign carry  = inc & at_top & ~clr;

  always_comb begin
    tens_d  = tens;
    units_d = units;
    if (clr) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc) begin
      if (at_top) begin
        tens_d  = '0;
        units_d = '0;
      end else if (units == 4'd9) begin
        tens_d  = tens + 4'd1;
        units_d = '0;
      end else begin
        units_d = units + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens  <= '0;
      units <= '0;
    end else begin
      tens  <= tens_d;
      units <= units_d;
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping and time-set controller for the on-screen clock display.
// Divides clk to a 1 Hz tick, keeps HH:MM:SS (24 h) as six BCD digits and runs the
// mode/increment set state machine. Optional macro CLOCK_BLINK_EN enables the blink mask.
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   btn_mode, btn_inc   asynchronous active-high buttons (synchronised here)
//   h1 h0 m1 m0 s1 s0   BCD time digits
//   edit_sel            0=RUN, 1=SET_H, 2=SET_M, 3=SET_S
//   blank_mask          per-digit blank, bit 5=h1 .. bit 0=s0 (0 unless CLOCK_BLINK_EN)
//   tick                one-cycle pulse each CLK_HZ cycles
// CLK_HZ must be at least 2.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic [1:0] edit_sel,
  output logic [5:0] blank_mask,
  output logic       tick
);

  localparam int unsigned CntW = $clog2(CLK_HZ);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLK_HZ - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLK_HZ / 2 - 1);

  // Button synchronisers and rising-edge detectors.
  logic [1:0] mode_sync_q, inc_sync_q;
  logic       mode_prev_q, inc_prev_q;
  logic       mode_p, inc_p, inc_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_sync_q <= '0;
      inc_sync_q  <= '0;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
    end else begin
      mode_sync_q <= {mode_sync_q[0], btn_mode};
      inc_sync_q  <= {inc_sync_q[0], btn_inc};
      mode_prev_q <= mode_sync_q[1];
      inc_prev_q  <= inc_sync_q[1];
    end
  end

  assign mode_p   = mode_sync_q[1] & ~mode_prev_q;
  assign inc_p    = inc_sync_q[1] & ~inc_prev_q;
  // A mode press wins over a coincident increment.
  assign inc_take = inc_p & ~mode_p;

  // Edit state machine.
  state_e state_q, state_d;
  logic   resume;

  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      unique case (state_q)
        StRun:  state_d = StSetH;
        StSetH: state_d = StSetM;
        StSetM: state_d = StSetS;
        StSetS: state_d = StRun;
      endcase
    end
  end

  // Restart the second on resume so the first tick is a full period later.
  assign resume = mode_p & (state_q == StSetS);

  // Prescaler; tick is registered and high exactly while the count sits at CntMax.
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick_q;

  always_comb begin
    if (resume || cnt_q == CntMax) cnt_d = '0;
    else                            cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= (cnt_d == CntMax);
    end
  end

  assign tick     = tick_q;
  assign edit_sel = state_q;

  // Field counters: carries cascade only in RUN; in SET states only the edited field moves.
  logic sec_inc, min_inc, hr_inc;
  logic sec_carry, min_carry, unused_hr_carry;

  assign sec_inc = (state_q == StRun) ? tick_q    : ((state_q == StSetS) & inc_take);
  assign min_inc = (state_q == StRun) ? sec_carry : ((state_q == StSetM) & inc_take);
  assign hr_inc  = (state_q == StRun) ? min_carry : ((state_q == StSetH) & inc_take);

  bcd2_mod_counter #(
    .TensMax  (tens_of(MINSEC_MAX)),
    .UnitsTop (units_of(MINSEC_MAX))
  ) u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sec_inc),
    .clr   (1'b0),
    .tens  (s1),
    .units (s0),
    .carry (sec_carry)
  );

  bcd2_mod_counter #(
    .TensMax  (tens_of(MINSEC_MAX)),
    .UnitsTop (units_of(MINSEC_MAX))
  ) u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (min_inc),
    .clr   (1'b0),
    .tens  (m1),
    .units (m0),
    .carry (min_carry)
  );

  bcd2_mod_counter #(
    .TensMax  (tens_of(HOURS_MAX)),
    .UnitsTop (units_of(HOURS_MAX))
  ) u_hr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hr_inc),
    .clr   (1'b0),
    .tens  (h1),
    .units (h0),
    .carry (unused_hr_carry)
  );

`ifdef CLOCK_BLINK_EN
  // Blink phase restarts at 0 on every state change so the edited field shows at once.
  logic       blink_q, blink_d;
  logic [5:0] mask_q, mask_d;

  always_comb begin
    if (state_d != state_q)                     blink_d = 1'b0;
    else if (cnt_q == CntHalf || cnt_q == CntMax) blink_d = ~blink_q;
    else                                        blink_d = blink_q;

    mask_d = '0;
    unique case (state_d)
      StRun:  mask_d = '0;
      StSetH: mask_d[5:4] = {2{blink_d}};
      StSetM: mask_d[3:2] = {2{blink_d}};
      StSetS: mask_d[1:0] = {2{blink_d}};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= 1'b0;
      mask_q  <= '0;
    end else begin
      blink_q <= blink_d;
      mask_q  <= mask_d;
    end
  end

  assign blank_mask = mask_q;
`else
  assign blank_mask = 6'b0;
`endif

endmodule
